// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the lab3 stopwatch controller: default sizing and mode-state encodings.
package stopwatch_ctrl_pkg;

  localparam int unsigned DEF_CNT_W   = 6;
  localparam int unsigned DEF_MAX_SEC = 59;
  localparam int unsigned DEF_MAX_MIN = 59;

  localparam logic [1:0] ST_RUN     = 2'd0;
  localparam logic [1:0] ST_PAUSE   = 2'd1;
  localparam logic [1:0] ST_ADJ_MIN = 2'd2;
  localparam logic [1:0] ST_ADJ_SEC = 2'd3;

endpackage

// File: rtl/stopwatch_ctrl_btn_sync_edge.sv
// Two-flop synchroniser for a raw button pin with a rising-edge pulse taken from the synchronised level.
module btn_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level,
  output logic rise_c
);

  logic meta;
  logic prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= 1'b0;
      level <= 1'b0;
      prev  <= 1'b0;
    end else begin
      meta  <= din;
      level <= meta;
      prev  <= level;
    end
  end

  assign rise_c = level & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch mode FSM (run / pause / adjust) owning the MM:SS registers and the adjust blink.
module stopwatch_ctrl
  import stopwatch_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = DEF_CNT_W,
  parameter int unsigned MAX_SEC = DEF_MAX_SEC,
  parameter int unsigned MAX_MIN = DEF_MAX_MIN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick_1hz,
  input  logic             tick_2hz,
  input  logic             tick_fast,
  input  logic             btn_pause,
  input  logic             btn_adj,
  input  logic             btn_sel,
  input  logic             btn_clr,
  output logic [CNT_W-1:0] min,
  output logic [CNT_W-1:0] sec,
  output logic             blink,
  output logic             blink_sel,
  output logic             running
);

  localparam logic [CNT_W-1:0] SEC_TOP = CNT_W'(MAX_SEC);
  localparam logic [CNT_W-1:0] MIN_TOP = CNT_W'(MAX_MIN);

  logic pause_lvl, pause_rise_c;
  logic adj_lvl, adj_rise_c;
  logic sel_lvl, sel_rise_c;
  logic clr_lvl, clr_rise_c;
  logic unused_c;

  logic [1:0]       state, state_n;
  logic             paused, paused_n;
  logic [CNT_W-1:0] min_n, sec_n;
  logic             blink_n;
  logic             adj_next_c;

  btn_sync_edge u_pause (.clk(clk), .rst_n(rst_n), .din(btn_pause), .level(pause_lvl), .rise_c(pause_rise_c));
  btn_sync_edge u_adj   (.clk(clk), .rst_n(rst_n), .din(btn_adj),   .level(adj_lvl),   .rise_c(adj_rise_c));
  btn_sync_edge u_sel   (.clk(clk), .rst_n(rst_n), .din(btn_sel),   .level(sel_lvl),   .rise_c(sel_rise_c));
  btn_sync_edge u_clr   (.clk(clk), .rst_n(rst_n), .din(btn_clr),   .level(clr_lvl),   .rise_c(clr_rise_c));

  assign unused_c = ^{pause_lvl, adj_rise_c, sel_rise_c, clr_lvl};

  // Out-of-range values restart at zero rather than counting on.
  function automatic logic [CNT_W-1:0] inc_wrap(input logic [CNT_W-1:0] v, input logic [CNT_W-1:0] top);
    return (v >= top) ? '0 : v + CNT_W'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RUN;
      paused    <= 1'b0;
      min       <= '0;
      sec       <= '0;
      blink     <= 1'b0;
      blink_sel <= 1'b0;
      running   <= 1'b1;
    end else begin
      state     <= state_n;
      paused    <= paused_n;
      min       <= min_n;
      sec       <= sec_n;
      blink     <= blink_n;
      blink_sel <= (state_n == ST_ADJ_SEC);
      running   <= (state_n == ST_RUN);
    end
  end

  always_comb begin
    state_n  = state;
    paused_n = paused;
    min_n    = min;
    sec_n    = sec;
    blink_n  = 1'b0;
    case (state)
      ST_RUN, ST_PAUSE: begin
        // Entering adjust takes precedence and swallows a coincident 1 Hz tick.
        if (adj_lvl) begin
          state_n = sel_lvl ? ST_ADJ_SEC : ST_ADJ_MIN;
        end else begin
          if ((state == ST_RUN) && tick_1hz) begin
            if (sec >= SEC_TOP) begin
              sec_n = '0;
              min_n = inc_wrap(min, MIN_TOP);
            end else begin
              sec_n = sec + CNT_W'(1);
            end
          end
          if (pause_rise_c) state_n = (state == ST_RUN) ? ST_PAUSE : ST_RUN;
        end
      end
      ST_ADJ_MIN, ST_ADJ_SEC: begin
        if (tick_2hz) begin
          if (state == ST_ADJ_SEC) sec_n = inc_wrap(sec, SEC_TOP);
          else                     min_n = inc_wrap(min, MIN_TOP);
        end
        blink_n = tick_fast ? ~blink : blink;
        if (!adj_lvl) state_n = paused ? ST_PAUSE : ST_RUN;
        else          state_n = sel_lvl ? ST_ADJ_SEC : ST_ADJ_MIN;
      end
      default: state_n = ST_RUN;
    endcase

    adj_next_c = (state_n == ST_ADJ_MIN) || (state_n == ST_ADJ_SEC);
    // The paused flag remembers where to return after adjust; it only moves outside adjust.
    if (!adj_next_c) begin
      paused_n = (state_n == ST_PAUSE);
      blink_n  = 1'b0;
    end
    if (clr_rise_c) begin
      min_n = '0;
      sec_n = '0;
    end
  end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus randomized traffic against a seconds-based reference model.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tick_1hz = 1'b0, tick_2hz = 1'b0, tick_fast = 1'b0;
  logic btn_pause = 1'b0, btn_adj = 1'b0, btn_sel = 1'b0, btn_clr = 1'b0;
  logic [5:0] min, sec;
  logic blink, blink_sel, running;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .tick_1hz(tick_1hz), .tick_2hz(tick_2hz), .tick_fast(tick_fast),
    .btn_pause(btn_pause), .btn_adj(btn_adj), .btn_sel(btn_sel), .btn_clr(btn_clr),
    .min(min), .sec(sec), .blink(blink), .blink_sel(blink_sel), .running(running)
  );

  // Reference model: time as total seconds, a coarse mode, and per-button pin history.
  typedef enum int {M_RUN, M_PAUSE, M_ADJ} mode_t;
  mode_t m_mode;
  int    m_t;
  bit    m_field_sec, m_was_paused, m_blink;
  bit [2:0] h_pause, h_adj, h_sel, h_clr;

  function automatic void model_reset();
    m_mode = M_RUN; m_t = 0; m_field_sec = 0; m_was_paused = 0; m_blink = 0;
    h_pause = '0; h_adj = '0; h_sel = '0; h_clr = '0;
  endfunction

  function automatic void model_edge();
    bit adj_s = h_adj[1];
    bit sel_s = h_sel[1];
    bit pause_e = h_pause[1] & ~h_pause[2];
    bit clr_e = h_clr[1] & ~h_clr[2];
    int mm = m_t / 60;
    int ss = m_t % 60;
    if (m_mode != M_ADJ) begin
      if (adj_s) begin
        m_was_paused = (m_mode == M_PAUSE);
        m_mode = M_ADJ;
        m_field_sec = sel_s;
      end else begin
        if (m_mode == M_RUN && tick_1hz) m_t = (m_t + 1) % 3600;
        if (pause_e) m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
      end
    end else begin
      if (tick_2hz) begin
        if (m_field_sec) m_t = mm * 60 + (ss + 1) % 60;
        else             m_t = ((mm + 1) % 60) * 60 + ss;
      end
      if (tick_fast) m_blink = ~m_blink;
      if (!adj_s) begin
        m_mode = m_was_paused ? M_PAUSE : M_RUN;
        m_blink = 0;
      end else begin
        m_field_sec = sel_s;
      end
    end
    if (clr_e) m_t = 0;
    h_pause = {h_pause[1:0], btn_pause};
    h_adj   = {h_adj[1:0], btn_adj};
    h_sel   = {h_sel[1:0], btn_sel};
    h_clr   = {h_clr[1:0], btn_clr};
  endfunction

  task automatic clk_step();
    @(posedge clk);
    if (rst_n) model_edge();
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) clk_step();
  endtask

  task automatic pulse_1hz();
    tick_1hz = 1'b1; clk_step(); tick_1hz = 1'b0;
  endtask

  task automatic pulse_2hz();
    tick_2hz = 1'b1; clk_step(); tick_2hz = 1'b0;
  endtask

  task automatic pulse_fast();
    tick_fast = 1'b1; clk_step(); tick_fast = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    model_reset();
    idle(3);
    checks++; if (min !== 6'd0) begin failures++; $display("FAIL reset_min got=%0d exp=0", min); end
    checks++; if (sec !== 6'd0) begin failures++; $display("FAIL reset_sec got=%0d exp=0", sec); end
    checks++; if (blink !== 1'b0) begin failures++; $display("FAIL reset_blink got=%b exp=0", blink); end
    checks++; if (blink_sel !== 1'b0) begin failures++; $display("FAIL reset_blink_sel got=%b exp=0", blink_sel); end
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL reset_running got=%b exp=1", running); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_count();
    for (int i = 0; i < 61; i++) begin
      pulse_1hz();
      checks++; if (sec !== 6'(m_t % 60)) begin failures++; $display("FAIL count_sec tick=%0d got=%0d exp=%0d", i, sec, m_t % 60); end
      idle($urandom_range(0, 2));
    end
    checks++; if ({min, sec, running} !== {6'd1, 6'd1, 1'b1}) begin
      failures++; $display("FAIL count_61 got=%0d:%0d run=%b exp=1:1 run=1", min, sec, running); end
  endtask

  task automatic test_wrap();
    btn_adj = 1'b1; btn_sel = 1'b0;
    idle(3);
    checks++; if ({running, blink_sel} !== 2'b00) begin
      failures++; $display("FAIL wrap_adj_min_entry got run=%b sel=%b exp run=0 sel=0", running, blink_sel); end
    for (int i = 0; i < 60; i++) if (m_t / 60 != 59) pulse_2hz();
    btn_sel = 1'b1;
    idle(3);
    checks++; if (blink_sel !== 1'b1) begin failures++; $display("FAIL wrap_adj_sec_sel got=%b exp=1", blink_sel); end
    for (int i = 0; i < 60; i++) if (m_t % 60 != 59) pulse_2hz();
    checks++; if ({min, sec} !== {6'd59, 6'd59}) begin
      failures++; $display("FAIL wrap_preload got=%0d:%0d exp=59:59", min, sec); end
    btn_adj = 1'b0; btn_sel = 1'b0;
    idle(3);
    pulse_1hz();
    checks++; if ({min, sec, running} !== {6'd0, 6'd0, 1'b1}) begin
      failures++; $display("FAIL wrap_rollover got=%0d:%0d run=%b exp=0:0 run=1", min, sec, running); end
  endtask

  task automatic test_pause();
    logic [5:0] hold_min, hold_sec;
    pulse_1hz(); pulse_1hz();
    hold_min = 6'(m_t / 60); hold_sec = 6'(m_t % 60);
    btn_pause = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      clk_step();
      checks++; if (running !== ((i >= 3) ? 1'b0 : 1'b1)) begin
        failures++; $display("FAIL pause_latency clk=%0d got=%b exp=%b", i, running, (i >= 3) ? 1'b0 : 1'b1); end
    end
    btn_pause = 1'b0;
    repeat (5) begin pulse_1hz(); idle(1); end
    checks++; if ({min, sec} !== {hold_min, hold_sec}) begin
      failures++; $display("FAIL pause_hold got=%0d:%0d exp=%0d:%0d", min, sec, hold_min, hold_sec); end
    btn_pause = 1'b1;
    idle(3);
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL pause_resume got=%b exp=1", running); end
    btn_pause = 1'b0;
    idle(3);
  endtask

  task automatic test_adjust_blink();
    logic [5:0] hold_min;
    bit exp_blink = 1'b0;
    btn_adj = 1'b1; btn_sel = 1'b1;
    idle(3);
    for (int i = 0; i < 60; i++) if (m_t % 60 != 58) pulse_2hz();
    hold_min = 6'(m_t / 60);
    for (int k = 0; k < 3; k++) begin
      pulse_2hz();
      checks++; if ({min, sec} !== {hold_min, 6'((59 + k) % 60)}) begin
        failures++; $display("FAIL adj_sec_step k=%0d got=%0d:%0d exp=%0d:%0d", k, min, sec, hold_min, (59 + k) % 60); end
    end
    pulse_1hz();
    checks++; if (sec !== 6'd1) begin failures++; $display("FAIL adj_ignores_1hz got=%0d exp=1", sec); end
    for (int k = 0; k < 3; k++) begin
      pulse_fast();
      exp_blink = ~exp_blink;
      checks++; if (blink !== exp_blink) begin
        failures++; $display("FAIL adj_blink_toggle k=%0d got=%b exp=%b", k, blink, exp_blink); end
    end
    btn_adj = 1'b0; btn_sel = 1'b0;
    idle(3);
    checks++; if ({blink, blink_sel, running} !== 3'b001) begin
      failures++; $display("FAIL adj_exit got blink=%b sel=%b run=%b exp 0 0 1", blink, blink_sel, running); end
  endtask

  task automatic test_pause_in_adj();
    btn_pause = 1'b1; idle(3); btn_pause = 1'b0; idle(2);
    checks++; if (running !== 1'b0) begin failures++; $display("FAIL padj_paused got=%b exp=0", running); end
    btn_adj = 1'b1; btn_sel = 1'b0; idle(3);
    btn_pause = 1'b1; idle(4); btn_pause = 1'b0; idle(2);
    pulse_fast();
    btn_adj = 1'b0; idle(3);
    checks++; if ({running, blink, blink_sel} !== 3'b000) begin
      failures++; $display("FAIL padj_return got run=%b blink=%b sel=%b exp 0 0 0", running, blink, blink_sel); end
    btn_pause = 1'b1; idle(3);
    checks++; if (running !== 1'b1) begin failures++; $display("FAIL padj_resume got=%b exp=1", running); end
    btn_pause = 1'b0; idle(3);
  endtask

  task automatic test_clr();
    btn_clr = 1'b1; idle(4); btn_clr = 1'b0; idle(2);
    checks++; if ({min, sec} !== 12'd0) begin failures++; $display("FAIL clr_plain got=%0d:%0d exp=0:0", min, sec); end
    repeat (5) pulse_1hz();
    checks++; if ({min, sec} !== {6'd0, 6'd5}) begin failures++; $display("FAIL clr_preset got=%0d:%0d exp=0:5", min, sec); end
    btn_clr = 1'b1;
    clk_step(); clk_step();
    pulse_1hz();
    checks++; if ({min, sec} !== 12'd0) begin failures++; $display("FAIL clr_vs_tick got=%0d:%0d exp=0:0", min, sec); end
    btn_clr = 1'b0; idle(3);
    repeat (7) pulse_1hz();
    rst_n = 1'b0;
    #1;
    checks++; if ({min, sec, blink, blink_sel, running} !== {12'd0, 3'b001}) begin
      failures++; $display("FAIL async_reset got=%0d:%0d blink=%b sel=%b run=%b", min, sec, blink, blink_sel, running); end
    model_reset();
    tick_1hz = 1'b1; idle(2); tick_1hz = 1'b0;
    rst_n = 1'b1;
    pulse_1hz();
    checks++; if ({min, sec} !== {6'd0, 6'd1}) begin failures++; $display("FAIL reset_first_tick got=%0d:%0d exp=0:1", min, sec); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      tick_1hz  = ($urandom_range(0, 3) == 0);
      tick_2hz  = ($urandom_range(0, 3) == 0);
      tick_fast = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 39) == 0) btn_pause = ~btn_pause;
      if ($urandom_range(0, 59) == 0) btn_adj = ~btn_adj;
      if ($urandom_range(0, 29) == 0) btn_sel = ~btn_sel;
      if ($urandom_range(0, 79) == 0) btn_clr = ~btn_clr;
      clk_step();
      checks++; if (min !== 6'(m_t / 60)) begin failures++; $display("FAIL rnd_min cyc=%0d got=%0d exp=%0d", i, min, m_t / 60); end
      checks++; if (sec !== 6'(m_t % 60)) begin failures++; $display("FAIL rnd_sec cyc=%0d got=%0d exp=%0d", i, sec, m_t % 60); end
      checks++; if (running !== (m_mode == M_RUN)) begin
        failures++; $display("FAIL rnd_running cyc=%0d got=%b exp=%b", i, running, m_mode == M_RUN); end
      checks++; if (blink !== m_blink) begin failures++; $display("FAIL rnd_blink cyc=%0d got=%b exp=%b", i, blink, m_blink); end
      checks++; if (blink_sel !== (m_mode == M_ADJ && m_field_sec)) begin
        failures++; $display("FAIL rnd_blink_sel cyc=%0d got=%b exp=%b", i, blink_sel, m_mode == M_ADJ && m_field_sec); end
    end
    tick_1hz = 1'b0; tick_2hz = 1'b0; tick_fast = 1'b0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_count();
    test_wrap();
    test_pause();
    test_adjust_blink();
    test_pause_in_adj();
    test_clr();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
